// File: rtl/eeprom_param_store_pkg.sv
// Shared definitions for the EEPROM parameter store: transceiver opcodes and sequencer states.
// Opcode values must match the AT93C46 transceiver.
package eeprom_param_store_pkg;

  typedef enum logic [1:0] {
    OP_EWEN  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } ee_op_e;

  localparam logic [5:0] EWEN_ADDR = 6'b110000;
  localparam int unsigned WAIT_HI_CLKS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EWEN,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT
  } state_e;

endpackage

// File: rtl/eeprom_param_regfile.sv
// 16-bit parameter register file: sequencer and CPU write ports (sequencer wins on
// collision), two asynchronous read ports. CPU indices >= NWORDS are ignored / read 0.
module eeprom_param_regfile #(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned AW     = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_seq_we,
  input  logic [AW-1:0] i_seq_idx,
  input  logic [15:0]   i_seq_wdata,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [15:0]   i_cpu_wdata,
  output logic [15:0]   o_seq_rdata_c,
  output logic [15:0]   o_cpu_rdata_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [15:0] r_mem [DEPTH];
  logic        w_cpu_in_range;

  assign w_cpu_in_range = 32'(i_cpu_addr) < NWORDS;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 16'h0000;
    end else begin
      if (i_cpu_we && w_cpu_in_range) r_mem[i_cpu_addr] <= i_cpu_wdata;
      // Later assignment takes effect, giving the sequencer priority on the same index.
      if (i_seq_we) r_mem[i_seq_idx] <= i_seq_wdata;
    end
  end

  assign o_seq_rdata_c = r_mem[i_seq_idx];
  assign o_cpu_rdata_c = w_cpu_in_range ? r_mem[i_cpu_addr] : 16'h0000;

endmodule

// File: rtl/eeprom_param_store.sv
// Command sequencer in front of the AT93C46 transceiver: loads the parameter register
// file from EEPROM (READ per word) or saves it back (EWEN, then WRITE per word).
module eeprom_param_store
  import eeprom_param_store_pkg::*;
#(
  parameter int unsigned NWORDS    = 8,
  parameter int unsigned AW        = 3,
  parameter logic [5:0]  BASE_ADDR = 6'd0,
  parameter bit          AUTOLOAD  = 1'b1,
  parameter int unsigned TO_BITS   = 20
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_save,
  input  logic [AW-1:0] i_reg_addr,
  input  logic [15:0]   i_reg_wdata,
  input  logic          i_reg_we,
  output logic [15:0]   o_reg_rdata_c,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic          o_valid,
  output logic          o_ee_send,
  output logic [1:0]    o_ee_opcode,
  output logic [5:0]    o_ee_address,
  output logic [15:0]   o_ee_data,
  input  logic [15:0]   i_ee_q,
  input  logic          i_ee_busy
);

  state_e             r_state;
  ee_op_e             r_op;
  logic [AW-1:0]      r_idx;
  logic [TO_BITS-1:0] r_cnt;
  logic               r_autoload;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_valid;
  logic               r_send;
  logic [1:0]         r_opcode;
  logic [5:0]         r_address;
  logic [15:0]        r_data;

  logic               w_seq_we;
  logic [15:0]        w_seq_rdata;

  // A READ result is captured in the same clock the sequencer leaves WAIT_LO.
  assign w_seq_we = (r_state == S_WAIT_LO) && !i_ee_busy && (r_op == OP_READ);

  eeprom_param_regfile #(
    .NWORDS (NWORDS),
    .AW     (AW)
  ) u_regfile (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_seq_we      (w_seq_we),
    .i_seq_idx     (r_idx),
    .i_seq_wdata   (i_ee_q),
    .i_cpu_we      (i_reg_we && !r_busy),
    .i_cpu_addr    (i_reg_addr),
    .i_cpu_wdata   (i_reg_wdata),
    .o_seq_rdata_c (w_seq_rdata),
    .o_cpu_rdata_c (o_reg_rdata_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_READ;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_autoload <= AUTOLOAD;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_valid    <= 1'b0;
      r_send     <= 1'b0;
      r_opcode   <= 2'b00;
      r_address  <= 6'd0;
      r_data     <= 16'h0000;
    end else begin
      r_done     <= 1'b0;
      r_send     <= 1'b0;
      r_autoload <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load || r_autoload) begin
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_op    <= OP_READ;
            r_state <= S_ISSUE;
          end else if (i_save) begin
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_idx   <= '0;
            r_op    <= OP_EWEN;
            r_state <= S_EWEN;
          end
        end
        S_EWEN: begin
          r_send    <= 1'b1;
          r_opcode  <= OP_EWEN;
          r_address <= EWEN_ADDR;
          r_data    <= 16'h0000;
          r_cnt     <= '0;
          r_state   <= S_WAIT_HI;
        end
        S_ISSUE: begin
          r_send    <= 1'b1;
          r_opcode  <= r_op;
          r_address <= 6'(BASE_ADDR + 6'(r_idx));
          r_data    <= (r_op == OP_WRITE) ? w_seq_rdata : 16'h0000;
          r_cnt     <= '0;
          r_state   <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (i_ee_busy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_LO;
          end else if (r_cnt == TO_BITS'(WAIT_HI_CLKS - 1)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + TO_BITS'(1);
          end
        end
        S_WAIT_LO: begin
          if (!i_ee_busy) begin
            r_cnt <= '0;
            if (r_op == OP_EWEN) begin
              r_op    <= OP_WRITE;
              r_idx   <= '0;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (r_cnt == '1) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + TO_BITS'(1);
          end
        end
        S_NEXT: begin
          if (r_idx == AW'(NWORDS - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_op == OP_READ) r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + AW'(1);
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_valid      = r_valid;
  assign o_ee_send    = r_send;
  assign o_ee_opcode  = r_opcode;
  assign o_ee_address = r_address;
  assign o_ee_data    = r_data;

endmodule

// File: tb/tb_eeprom_param_store.sv
// Bench for eeprom_param_store: transceiver + AT93C46 behavioural model at the
// Send/Busy/Q level, randomized register contents, frame log checked against expectations.
module tb_eeprom_param_store;

  localparam int unsigned NW  = 8;
  localparam int unsigned AWB = 4;
  localparam int unsigned TOB = 8;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] EW = 2'b00;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_load = 1'b0;
  logic           i_save = 1'b0;
  logic [AWB-1:0] i_reg_addr = '0;
  logic [15:0]    i_reg_wdata = 16'h0;
  logic           i_reg_we = 1'b0;
  logic [15:0]    o_reg_rdata_c;
  logic           o_busy, o_done, o_error, o_valid, o_ee_send;
  logic [1:0]     o_ee_opcode;
  logic [5:0]     o_ee_address;
  logic [15:0]    o_ee_data;

  // EEPROM/transceiver model state
  logic           m_busy;
  logic [15:0]    m_q;
  int             m_cnt;
  logic [1:0]     m_op;
  logic [5:0]     m_addr;
  logic [15:0]    m_data;
  bit             m_ewen;
  bit             stuck = 1'b0;
  bit [15:0]      mem [64];
  bit             pl_req = 1'b0;
  logic [15:0]    pl_val [NW];
  int             bad_send = 0;
  int             unstable = 0;
  logic [1:0]     log_op [$];
  logic [5:0]     log_addr [$];
  logic [15:0]    log_data [$];

  // Bench expectations
  logic [15:0]    exp_reg [NW];
  logic [15:0]    exp_mem [NW];
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  eeprom_param_store #(
    .NWORDS    (NW),
    .AW        (AWB),
    .BASE_ADDR (6'd0),
    .AUTOLOAD  (1'b1),
    .TO_BITS   (TOB)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_load        (i_load),
    .i_save        (i_save),
    .i_reg_addr    (i_reg_addr),
    .i_reg_wdata   (i_reg_wdata),
    .i_reg_we      (i_reg_we),
    .o_reg_rdata_c (o_reg_rdata_c),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_valid       (o_valid),
    .o_ee_send     (o_ee_send),
    .o_ee_opcode   (o_ee_opcode),
    .o_ee_address  (o_ee_address),
    .o_ee_data     (o_ee_data),
    .i_ee_q        (m_q),
    .i_ee_busy     (m_busy)
  );

  // Transceiver + EEPROM: accepts Send when idle, busy 1 clk later for a random frame length.
  always @(posedge clk or posedge rst) begin
    if (pl_req) for (int i = 0; i < int'(NW); i++) mem[i] <= pl_val[i];
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_q    <= 16'h0;
    end else begin
      if (o_ee_send && m_busy) bad_send <= bad_send + 1;
      if (m_busy && (o_ee_opcode !== m_op || o_ee_address !== m_addr || o_ee_data !== m_data))
        unstable <= unstable + 1;
      if (!m_busy && o_ee_send) begin
        m_busy <= 1'b1;
        m_op   <= o_ee_opcode;
        m_addr <= o_ee_address;
        m_data <= o_ee_data;
        m_cnt  <= int'($urandom_range(3, 12));
        log_op.push_back(o_ee_opcode);
        log_addr.push_back(o_ee_address);
        log_data.push_back(o_ee_data);
      end else if (m_busy) begin
        if (m_cnt > 0) m_cnt <= m_cnt - 1;
        else if (!(stuck && m_op == WR)) begin
          m_busy <= 1'b0;
          case (m_op)
            RD: m_q <= mem[m_addr];
            WR: if (m_ewen) mem[m_addr] <= m_data;
            EW: m_ewen <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic preload_random();
    for (int i = 0; i < int'(NW); i++) begin
      pl_val[i]  = 16'($urandom);
      exp_mem[i] = pl_val[i];
    end
    pl_req = 1'b1;
    @(negedge clk);
    pl_req = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (o_done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(NW); i++) begin
      pl_val[i]  = 16'hA000 + 16'(i);
      exp_mem[i] = pl_val[i];
      exp_reg[i] = 16'h0;
    end
    pl_req = 1'b1;
    repeat (3) @(negedge clk);
    pl_req = 1'b0;
    checks++;
    if ({o_busy, o_done, o_error, o_valid, o_ee_send, o_ee_opcode, o_ee_address, o_ee_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b valid=%b send=%b op=%b addr=%h data=%h, all required 0",
               o_busy, o_done, o_error, o_valid, o_ee_send, o_ee_opcode, o_ee_address, o_ee_data);
    end
    i_reg_addr = AWB'(3);
    #1;
    checks++;
    if (o_reg_rdata_c !== 16'h0) begin
      errors++;
      $display("FAIL reset_regfile: reg3=%h required 0000", o_reg_rdata_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_autoload();
    bit seen;
    int n;
    wait_done(3000, seen, n);
    checks++;
    if (!seen) begin errors++; $display("FAIL autoload_done: no Done within 3000 clks"); end
    checks++;
    if ({o_valid, o_busy, o_error} !== 3'b100) begin
      errors++;
      $display("FAIL autoload_flags: valid/busy/err=%b required 100", {o_valid, o_busy, o_error});
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL autoload_done_width: done=%b required 0 one clk later", o_done); end
    checks++;
    if (log_op.size() != int'(NW)) begin
      errors++;
      $display("FAIL autoload_frames: frames=%0d required %0d", log_op.size(), NW);
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if (log_op[i] !== RD || log_addr[i] !== 6'(i)) begin
          errors++;
          $display("FAIL autoload_frame%0d: op=%b addr=%0d required op=10 addr=%0d", i, log_op[i], log_addr[i], i);
        end
      end
    end
    for (int i = 0; i < int'(NW); i++) begin
      exp_reg[i] = exp_mem[i];
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== exp_reg[i]) begin
        errors++;
        $display("FAIL autoload_reg%0d: got %h required %h", i, o_reg_rdata_c, exp_reg[i]);
      end
    end
  endtask

  task automatic test_save();
    bit seen;
    int n, base;
    for (int i = 0; i < int'(NW); i++) begin
      @(negedge clk);
      i_reg_addr  = AWB'(i);
      i_reg_wdata = (i == 2) ? 16'h1234 : 16'($urandom);
      exp_reg[i]  = i_reg_wdata;
      i_reg_we    = 1'b1;
    end
    @(negedge clk);
    i_reg_addr  = AWB'(NW);
    i_reg_wdata = 16'hBEEF;
    @(negedge clk);
    i_reg_we = 1'b0;
    #1;
    checks++;
    if (o_reg_rdata_c !== 16'h0) begin errors++; $display("FAIL oor_write_read: reg8=%h required 0000", o_reg_rdata_c); end
    i_reg_addr = AWB'(2);
    #1;
    checks++;
    if (o_reg_rdata_c !== 16'h1234) begin errors++; $display("FAIL cpu_write: reg2=%h required 1234", o_reg_rdata_c); end
    base = log_op.size();
    @(negedge clk); i_save = 1'b1;
    @(negedge clk); i_save = 1'b0;
    wait_done(3000, seen, n);
    checks++;
    if (!seen || o_error !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL save_end: done_seen=%b err=%b valid=%b required 1/0/1", seen, o_error, o_valid);
    end
    checks++;
    if (log_op.size() - base != int'(NW) + 1) begin
      errors++;
      $display("FAIL save_frames: frames=%0d required %0d", log_op.size() - base, NW + 1);
    end else begin
      checks++;
      if (log_op[base] !== EW || log_addr[base] !== 6'b110000) begin
        errors++;
        $display("FAIL save_ewen: op=%b addr=%b required 00/110000", log_op[base], log_addr[base]);
      end
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if (log_op[base+1+i] !== WR || log_addr[base+1+i] !== 6'(i) || log_data[base+1+i] !== exp_reg[i]) begin
          errors++;
          $display("FAIL save_write%0d: op=%b addr=%0d data=%h required 01/%0d/%h",
                   i, log_op[base+1+i], log_addr[base+1+i], log_data[base+1+i], i, exp_reg[i]);
        end
      end
    end
    for (int i = 0; i < int'(NW); i++) begin
      exp_mem[i] = exp_reg[i];
      checks++;
      if (mem[i] !== exp_mem[i]) begin errors++; $display("FAIL save_eeprom%0d: got %h required %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_load_save_same();
    bit seen;
    int n, base;
    preload_random();
    base = log_op.size();
    @(negedge clk); i_load = 1'b1; i_save = 1'b1;
    @(negedge clk); i_load = 1'b0; i_save = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_load: busy=%b valid=%b required 1/0", o_busy, o_valid);
    end
    i_save = 1'b1;
    @(negedge clk); i_save = 1'b0;
    wait_done(3000, seen, n);
    repeat (40) @(negedge clk);
    checks++;
    if (!seen || log_op.size() - base != int'(NW)) begin
      errors++;
      $display("FAIL load_wins_frames: done_seen=%b frames=%0d required 1/%0d", seen, log_op.size() - base, NW);
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if (log_op[base+i] !== RD) begin errors++; $display("FAIL load_wins_op%0d: op=%b required 10", i, log_op[base+i]); end
      end
    end
    for (int i = 0; i < int'(NW); i++) begin
      exp_reg[i] = exp_mem[i];
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== exp_reg[i]) begin errors++; $display("FAIL load_reg%0d: got %h required %h", i, o_reg_rdata_c, exp_reg[i]); end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int n, base;
    stuck = 1'b1;
    base = log_op.size();
    @(negedge clk); i_save = 1'b1;
    @(negedge clk); i_save = 1'b0;
    wait_done(2000, seen, n);
    checks++;
    if (!seen || n < int'(2**TOB - 1)) begin
      errors++;
      $display("FAIL timeout_done: done_seen=%b after %0d clks required 1 after >= %0d", seen, n, 2**TOB - 1);
    end
    checks++;
    if ({o_error, o_busy, o_valid} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_flags: err/busy/valid=%b required 101", {o_error, o_busy, o_valid});
    end
    checks++;
    if (log_op.size() - base != 2) begin
      errors++;
      $display("FAIL timeout_frames: frames=%0d required 2", log_op.size() - base);
    end
    for (int i = 0; i < int'(NW); i++) begin
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== exp_reg[i]) begin errors++; $display("FAIL timeout_reg%0d: got %h required %h", i, o_reg_rdata_c, exp_reg[i]); end
    end
    stuck = 1'b0;
    repeat (20) @(negedge clk);
    preload_random();
    @(negedge clk); i_load = 1'b1;
    @(negedge clk); i_load = 1'b0;
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL error_clear: err=%b busy=%b required 0/1", o_error, o_busy);
    end
    wait_done(3000, seen, n);
    checks++;
    if (!seen || o_error !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL reload_end: done_seen=%b err=%b valid=%b required 1/0/1", seen, o_error, o_valid);
    end
    for (int i = 0; i < int'(NW); i++) exp_reg[i] = exp_mem[i];
  endtask

  task automatic test_regwe_during_load();
    bit seen = 1'b0;
    int n = 0;
    preload_random();
    @(negedge clk); i_load = 1'b1;
    @(negedge clk); i_load = 1'b0;
    while (!seen && n < 3000) begin
      i_reg_we    = o_busy;
      i_reg_addr  = AWB'($urandom_range(0, NW - 1));
      i_reg_wdata = 16'($urandom);
      @(negedge clk);
      n++;
      if (o_done) seen = 1'b1;
    end
    i_reg_we = 1'b0;
    checks++;
    if (!seen || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL regwe_load_end: done_seen=%b valid=%b required 1/1", seen, o_valid);
    end
    for (int i = 0; i < int'(NW); i++) begin
      exp_reg[i] = exp_mem[i];
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== exp_reg[i]) begin errors++; $display("FAIL regwe_load_reg%0d: got %h required %h", i, o_reg_rdata_c, exp_reg[i]); end
    end
    for (int a = int'(NW); a < int'(2**AWB); a += 7) begin
      i_reg_addr = AWB'(a);
      #1;
      checks++;
      if (o_reg_rdata_c !== 16'h0) begin errors++; $display("FAIL oor_read%0d: got %h required 0000", a, o_reg_rdata_c); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n = 0, base;
    base = log_op.size();
    @(negedge clk); i_load = 1'b1;
    @(negedge clk); i_load = 1'b0;
    while (log_op.size() - base < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (log_op.size() - base != 4) begin
      errors++;
      $display("FAIL mid_reach4: frames=%0d required 4", log_op.size() - base);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_error, o_valid, o_ee_send, o_ee_opcode, o_ee_address, o_ee_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b valid=%b send=%b op=%b addr=%h data=%h, all required 0",
               o_busy, o_done, o_error, o_valid, o_ee_send, o_ee_opcode, o_ee_address, o_ee_data);
    end
    for (int i = 0; i < int'(NW); i++) begin
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== 16'h0) begin errors++; $display("FAIL mid_reset_reg%0d: got %h required 0000", i, o_reg_rdata_c); end
    end
    repeat (2) @(negedge clk);
    base = log_op.size();
    rst = 1'b0;
    wait_done(3000, seen, n);
    checks++;
    if (!seen || o_valid !== 1'b1 || log_op.size() - base != int'(NW)) begin
      errors++;
      $display("FAIL mid_restart: done_seen=%b valid=%b frames=%0d required 1/1/%0d", seen, o_valid, log_op.size() - base, NW);
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        checks++;
        if (log_op[base+i] !== RD || log_addr[base+i] !== 6'(i)) begin
          errors++;
          $display("FAIL mid_restart_frame%0d: op=%b addr=%0d required 10/%0d", i, log_op[base+i], log_addr[base+i], i);
        end
      end
    end
    for (int i = 0; i < int'(NW); i++) begin
      exp_reg[i] = exp_mem[i];
      i_reg_addr = AWB'(i);
      #1;
      checks++;
      if (o_reg_rdata_c !== exp_reg[i]) begin errors++; $display("FAIL mid_restart_reg%0d: got %h required %h", i, o_reg_rdata_c, exp_reg[i]); end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (bad_send != 0) begin errors++; $display("FAIL send_width: %0d Send clks while transceiver busy, required 0", bad_send); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL cmd_stable: %0d clks with changing Opcode/Address/Data, required 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_autoload();
    test_save();
    test_load_save_same();
    test_timeout();
    test_regwe_during_load();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
